// File: rtl/comma_lock_detect_pkg.sv
// rtl/comma_lock_detect_pkg.sv - shared FSM encodings and parameter legality check for comma_lock_detect
//
// Contents:
//   lock_state_t  : HUNT / CHECK / LOCKED state encoding (HUNT is the reset state, value 0)
//   params_legal  : elaboration-time check of the parameter set
package comma_lock_detect_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } lock_state_t;

    // Returns 1 when the parameter combination is usable by the detector.
    function automatic bit params_legal(
        input int word_size,
        input int index_size,
        input int pat_len,
        input int lock_hits,
        input int unlock_misses
    );
        bit ok;
        ok = 1'b1;
        if (word_size < 2)                      ok = 1'b0;
        if (index_size < 1)                     ok = 1'b0;
        if ((2 ** index_size) < word_size)      ok = 1'b0;
        if (pat_len < 2 || pat_len > word_size) ok = 1'b0;
        if (lock_hits < 1)                      ok = 1'b0;
        if (unlock_misses < 1)                  ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/comma_priority_enc.sv
// rtl/comma_priority_enc.sv - comma match vector and lowest-index priority encoder
//
// Ports:
//   ext        in  WORD_SIZE+PAT_LEN-1  search vector {word, tail}
//   match_vec  out WORD_SIZE            bit i set when ext[i+PAT_LEN-1:i] == PATTERN
//   any_match  out 1                    at least one bit of match_vec set
//   low_index  out INDEX_SIZE           lowest set position of match_vec, 0 when none
module comma_priority_enc #(
    parameter int                 WORD_SIZE  = 16,
    parameter int                 INDEX_SIZE = 4,
    parameter int                 PAT_LEN    = 3,
    parameter logic [PAT_LEN-1:0] PATTERN    = 3'b101
) (
    input  logic [WORD_SIZE+PAT_LEN-2:0] ext,
    output logic [WORD_SIZE-1:0]         match_vec,
    output logic                         any_match,
    output logic [INDEX_SIZE-1:0]        low_index
);

    always_comb begin
        match_vec = '0;
        for (int i = 0; i < WORD_SIZE; i++) begin
            match_vec[i] = (ext[i +: PAT_LEN] == PATTERN);
        end
    end

    assign any_match = |match_vec;

    // Scan from the top down so the last assignment wins with the lowest index.
    always_comb begin
        low_index = '0;
        for (int i = WORD_SIZE - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                low_index = INDEX_SIZE'(i);
            end
        end
    end

endmodule

// File: rtl/comma_lock_detect.sv
// rtl/comma_lock_detect.sv - comma pattern search with HUNT/CHECK/LOCKED alignment lock
//
// Ports:
//   trigger      in  1             clock, rising edge
//   reset_n      in  1             asynchronous active-low reset
//   word_in      in  WORD_SIZE     data word to search
//   valid_in     in  1             word_in qualifier
//   valid_out    out 1             one-cycle pulse per accepted word
//   found        out 1             last accepted word contained a match
//   index_out    out INDEX_SIZE    lowest matching index of last accepted word
//   match_count  out INDEX_SIZE+1  number of matching positions (overlaps counted)
//   locked       out 1             FSM is in LOCKED
//   lock_index   out INDEX_SIZE    candidate / locked alignment index
module comma_lock_detect
    import comma_lock_detect_pkg::*;
#(
    parameter int                 WORD_SIZE     = 16,
    parameter int                 INDEX_SIZE    = 4,
    parameter int                 PAT_LEN       = 3,
    parameter logic [PAT_LEN-1:0] PATTERN       = 3'b101,
    parameter int                 LOCK_HITS     = 3,
    parameter int                 UNLOCK_MISSES = 2
) (
    input  logic                  trigger,
    input  logic                  reset_n,
    input  logic [WORD_SIZE-1:0]  word_in,
    input  logic                  valid_in,
    output logic                  valid_out,
    output logic                  found,
    output logic [INDEX_SIZE-1:0] index_out,
    output logic [INDEX_SIZE:0]   match_count,
    output logic                  locked,
    output logic [INDEX_SIZE-1:0] lock_index
);

    if (!params_legal(WORD_SIZE, INDEX_SIZE, PAT_LEN, LOCK_HITS, UNLOCK_MISSES)) begin : g_bad_params
        $error("comma_lock_detect: illegal parameter combination");
    end

    localparam int HITS_W = $clog2(LOCK_HITS + 1);
    localparam int MISS_W = $clog2(UNLOCK_MISSES + 1);

    // Top PAT_LEN-1 bits of the previous accepted word, so straddling commas are seen.
    logic [PAT_LEN-2:0]          tail;
    logic [WORD_SIZE+PAT_LEN-2:0] ext;

    logic [WORD_SIZE-1:0]  match_vec;
    logic                  any_match;
    logic [INDEX_SIZE-1:0] low_index;
    logic [INDEX_SIZE:0]   count_comb;

    lock_state_t           state, state_next;
    logic [HITS_W-1:0]     hits, hits_next;
    logic [MISS_W-1:0]     misses, misses_next;
    logic [INDEX_SIZE-1:0] lock_index_next;
    logic                  hit_at_lock;

    assign ext = {word_in, tail};

    comma_priority_enc #(
        .WORD_SIZE  (WORD_SIZE),
        .INDEX_SIZE (INDEX_SIZE),
        .PAT_LEN    (PAT_LEN),
        .PATTERN    (PATTERN)
    ) u_enc (
        .ext       (ext),
        .match_vec (match_vec),
        .any_match (any_match),
        .low_index (low_index)
    );

    always_comb begin
        count_comb = '0;
        for (int i = 0; i < WORD_SIZE; i++) begin
            count_comb = count_comb + (INDEX_SIZE+1)'(match_vec[i]);
        end
    end

    assign hit_at_lock = match_vec[lock_index];

    // Next-state logic; only consumed on accepted words.
    always_comb begin
        state_next      = state;
        hits_next       = hits;
        misses_next     = misses;
        lock_index_next = lock_index;
        case (state)
            ST_HUNT: begin
                if (any_match) begin
                    lock_index_next = low_index;
                    hits_next       = HITS_W'(1);
                    misses_next     = '0;
                    state_next      = (LOCK_HITS <= 1) ? ST_LOCKED : ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (hit_at_lock) begin
                    if (hits >= HITS_W'(LOCK_HITS - 1)) begin
                        hits_next   = HITS_W'(LOCK_HITS);
                        misses_next = '0;
                        state_next  = ST_LOCKED;
                    end else begin
                        hits_next = hits + HITS_W'(1);
                    end
                end else if (any_match) begin
                    lock_index_next = low_index;
                    hits_next       = HITS_W'(1);
                end else begin
                    hits_next  = '0;
                    state_next = ST_HUNT;
                end
            end
            ST_LOCKED: begin
                if (hit_at_lock) begin
                    misses_next = '0;
                end else if (misses >= MISS_W'(UNLOCK_MISSES - 1)) begin
                    misses_next = '0;
                    hits_next   = '0;
                    state_next  = ST_HUNT;
                end else begin
                    misses_next = misses + MISS_W'(1);
                end
            end
            default: begin
                hits_next   = '0;
                misses_next = '0;
                state_next  = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge trigger or negedge reset_n) begin
        if (!reset_n) begin
            tail        <= '0;
            valid_out   <= 1'b0;
            found       <= 1'b0;
            index_out   <= '0;
            match_count <= '0;
            locked      <= 1'b0;
            lock_index  <= '0;
            state       <= ST_HUNT;
            hits        <= '0;
            misses      <= '0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                tail        <= word_in[WORD_SIZE-1 -: PAT_LEN-1];
                found       <= any_match;
                index_out   <= low_index;
                match_count <= count_comb;
                state       <= state_next;
                hits        <= hits_next;
                misses      <= misses_next;
                lock_index  <= lock_index_next;
                locked      <= (state_next == ST_LOCKED);
            end
        end
    end

endmodule

// File: tb/tb_comma_lock_detect.sv
// tb/tb_comma_lock_detect.sv - directed vector bench for comma_lock_detect
module tb_comma_lock_detect;

    logic        trigger;
    logic        reset_n;
    logic [15:0] word_in;
    logic        valid_in;
    logic        valid_out;
    logic        found;
    logic [3:0]  index_out;
    logic [4:0]  match_count;
    logic        locked;
    logic [3:0]  lock_index;

    int n_cmp;
    int n_bad;

    comma_lock_detect dut (
        .trigger     (trigger),
        .reset_n     (reset_n),
        .word_in     (word_in),
        .valid_in    (valid_in),
        .valid_out   (valid_out),
        .found       (found),
        .index_out   (index_out),
        .match_count (match_count),
        .locked      (locked),
        .lock_index  (lock_index)
    );

    initial trigger = 1'b0;
    always #5 trigger = ~trigger;

    typedef struct {
        logic [15:0] word;
        logic        valid;
        logic        vo;
        logic        f;
        logic [3:0]  idx;
        logic [4:0]  cnt;
        logic        lk;
        logic [3:0]  li;
    } vec_t;

    vec_t tbl[23];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic vo, input logic f, input logic [3:0] idx,
                           input logic [4:0] cnt, input logic lk, input logic [3:0] li);
        chk({tag, "_valid_out"},   int'(valid_out),   int'(vo));
        chk({tag, "_found"},       int'(found),       int'(f));
        chk({tag, "_index_out"},   int'(index_out),   int'(idx));
        chk({tag, "_match_count"}, int'(match_count), int'(cnt));
        chk({tag, "_locked"},      int'(locked),      int'(lk));
        chk({tag, "_lock_index"},  int'(lock_index),  int'(li));
    endtask

    // Called at a negedge: drive, let one rising edge pass, return at next negedge.
    task automatic apply(input logic [15:0] w, input logic v);
        word_in  = w;
        valid_in = v;
        @(posedge trigger);
        @(negedge trigger);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;

        //            word      v   vo f  idx  cnt lk li
        tbl[0]  = '{16'h0005, 1, 1, 1, 2, 1, 0, 2};  // first word, tail 0
        tbl[1]  = '{16'h0AA0, 1, 1, 1, 7, 3, 0, 7};  // candidate moves to 7
        tbl[2]  = '{16'hFFFF, 1, 1, 0, 0, 0, 0, 7};  // no match -> HUNT
        tbl[3]  = '{16'h0000, 1, 1, 0, 0, 0, 0, 7};  // tail 11, still none
        tbl[4]  = '{16'h4000, 1, 1, 0, 0, 0, 0, 7};
        tbl[5]  = '{16'h0001, 1, 1, 1, 0, 1, 0, 0};  // straddle with tail 01
        tbl[6]  = '{16'h0005, 0, 0, 1, 0, 1, 0, 0};  // gap: nothing moves
        tbl[7]  = '{16'h0005, 1, 1, 1, 2, 1, 0, 2};  // CHECK retargets to 2
        tbl[8]  = '{16'h0005, 1, 1, 1, 2, 1, 0, 2};  // hits 2
        tbl[9]  = '{16'h0005, 0, 0, 1, 2, 1, 0, 2};  // gap
        tbl[10] = '{16'h0005, 1, 1, 1, 2, 1, 1, 2};  // hits 3 -> LOCKED
        tbl[11] = '{16'hFFFF, 0, 0, 1, 2, 1, 1, 2};  // gap
        tbl[12] = '{16'hFFFF, 1, 1, 0, 0, 0, 1, 2};  // miss 1
        tbl[13] = '{16'hFFFF, 0, 0, 0, 0, 0, 1, 2};  // gap
        tbl[14] = '{16'hFFFF, 1, 1, 0, 0, 0, 0, 2};  // miss 2 -> HUNT
        tbl[15] = '{16'h0005, 1, 1, 1, 2, 1, 0, 2};
        tbl[16] = '{16'h0005, 1, 1, 1, 2, 1, 0, 2};
        tbl[17] = '{16'h0005, 1, 1, 1, 2, 1, 1, 2};  // locked again
        tbl[18] = '{16'hFFFF, 1, 1, 0, 0, 0, 1, 2};  // miss 1
        tbl[19] = '{16'h0005, 1, 1, 1, 2, 1, 1, 2};  // hit clears misses
        tbl[20] = '{16'hFFFF, 1, 1, 0, 0, 0, 1, 2};  // miss 1 only
        tbl[21] = '{16'h0005, 1, 1, 1, 2, 1, 1, 2};
        tbl[22] = '{16'h5555, 1, 1, 1, 2, 7, 1, 2};  // overlapping matches

        reset_n  = 1'b0;
        word_in  = 16'h0000;
        valid_in = 1'b0;
        @(negedge trigger);
        @(negedge trigger);
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        @(negedge trigger);

        for (int i = 0; i < 23; i++) begin
            apply(tbl[i].word, tbl[i].valid);
            chk_all($sformatf("v%0d", i), tbl[i].vo, tbl[i].f, tbl[i].idx,
                    tbl[i].cnt, tbl[i].lk, tbl[i].li);
        end

        // Asynchronous reset while locked: outputs clear before any clock edge.
        valid_in = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 0);
        @(negedge trigger);
        reset_n = 1'b1;
        @(negedge trigger);

        // Tail must restart at 0: with the old tail (01) this word would match at 0.
        apply(16'h0001, 1'b1);
        chk_all("post_rst_tail", 1, 0, 0, 0, 0, 0);

        // FSM restarted in HUNT: needs three full hits to lock again.
        apply(16'h0005, 1'b1);
        chk_all("post_rst_w1", 1, 1, 2, 1, 0, 2);
        apply(16'h0005, 1'b1);
        chk_all("post_rst_w2", 1, 1, 2, 1, 0, 2);
        apply(16'h0005, 1'b1);
        chk_all("post_rst_w3", 1, 1, 2, 1, 1, 2);

        apply(16'h0005, 1'b0);
        chk_all("post_rst_idle", 0, 1, 2, 1, 1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
